bcd_counter_chain: RTL
======================

// Module: bcd_counter_chain
// PURPOSE
//   Parametrised multi-digit BCD up/down counter with synchronous load and terminal-count flags.
//   Generalises the single 0-9 digit counter to DIGITS cascaded digits with direction control and preset.
//   Drives keypad-entry / countdown timers in the home-intruding alarm path (e.g. the arming delay).
// PARAMETERS
//   DIGITS     4  number of cascaded BCD digits; count width = 4*DIGITS
//   DIGIT_MAX  9  terminal value of every digit (1..9); e.g. 5 for a 0-5 tens-of-seconds digit
// PORTS
//   clk         in   1          single clock, all state on posedge
//   reset       in   1          synchronous, active-high
//   enable      in   1          count step qualifier, one step per cycle while high
//   up          in   1          1 = increment, 0 = decrement
//   load        in   1          synchronous preset from load_value
//   load_value  in   4*DIGITS   preset, digit i at bits [4i+3:4i], digit 0 = least significant
//   count       out  4*DIGITS   current value, BCD per digit
//   rollover    out  1          comb: enable & up & all digits == DIGIT_MAX & !load
//   borrow      out  1          comb: enable & !up & all digits == 0 & !load
//   zero        out  1          comb: all digits == 0
// BEHAVIOUR
//   - Single clock; reset is synchronous and active-high. Priority per edge: reset > load > enable.
//   - Reset: count = 0. Combinational outputs follow from that: zero = 1; rollover = borrow = 0.
//   - Load: each digit takes min(load_value digit, DIGIT_MAX); values above DIGIT_MAX clamp, never stored raw.
//   - Load ignores enable/up in that cycle; count visible the following cycle.
//   - Enable & up: digit 0 increments.
//     Digit i steps only when all lower digits == DIGIT_MAX (ripple carry, same cycle).
//     A stepping digit at DIGIT_MAX wraps to 0.
//   - Enable & !up: digit 0 decrements.
//     Digit i steps only when all lower digits == 0.
//     A stepping digit at 0 wraps to DIGIT_MAX.
//   - Latency: count updates one edge after enable; rollover/borrow are combinational in the cycle that wraps.
//   - Full wrap (no macro): up at all-max -> all 0; down at all-0 -> all-max.
//   - enable low: count holds, rollover = borrow = 0 regardless of count.
//   - Direction change: takes effect on the same edge; there is no pipeline to flush.
//   - Reset mid-count: wins over load/enable in that cycle.
//   - Invariant: every digit <= DIGIT_MAX at all times after the first reset.
// CONFIGURATION
//   BCD_CHAIN_SATURATE_EN
//     Defined:
//       - up at all-max holds all-max; down at all-0 holds all-0.
//       - rollover/borrow still assert for that cycle (saturation attempt is visible).
//       - Lower digits do not wrap while the chain is saturated.
//     Undefined:
//       - Wrap-around exactly as in BEHAVIOUR.
// STRUCTURE
//   Package bcd_pkg:
//     - localparam BCD_W = 4
//     - typedef logic [BCD_W-1:0] bcd_digit_t
//     - function bcd_clamp(digit, max)
//   Sub-module bcd_digit (one instance per digit, generate loop):
//     - Inputs: clk, reset, load, load_digit, step, up, max.
//     - Outputs: digit, at_max, at_zero.
//   Top level:
//     - Builds step_i = enable & !load & AND(lower at_max) for up, AND(lower at_zero) for down.
//     - Derives flags and gates saturation.
//   `ifdef FORMAL block:
//     - Assert digit <= DIGIT_MAX after reset.
//     - Assert rollover implies the next count == 0 (no macro).
//     - Cover a full wrap both directions.
// TESTING (DIGITS=2, DIGIT_MAX=9 unless stated)
//   1. reset=1 one cycle, then enable=1 up=1 for 100 cycles
//      -> counts 00..99; rollover=1 only at 99; next count 00.
//   2. load=1 load_value=8'h10, then enable=1 up=0 for 2 cycles
//      -> 10, 09, 08 (borrow across digit); borrow stays 0.
//   3. count=00, enable=1 up=0
//      -> borrow=1 that cycle; next count 99 (no macro), or 00 with BCD_CHAIN_SATURATE_EN.
//   4. load_value=8'hAF with load=1 enable=1 up=1
//      -> count=99 (clamped, enable ignored); rollover=0 during load.
//   5. count=47, reset=1 together with load=1 and enable=1
//      -> count=00, zero=1.
//   6. DIGITS=2, DIGIT_MAX=5, up from 00
//      -> ..05, 10, ..55, 00; rollover at 55.

Source files
------------

// File: rtl/bcd_pkg.sv
// ============================================================================
// Package : bcd_pkg
// Brief   : Shared BCD digit type, width constant and load clamp helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit, input bcd_digit_t max);
      return (digit > max) ? max : digit;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit.sv
// ============================================================================
// Module : bcd_digit
// Brief  : One BCD digit with clamped load and wrap-around up/down step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  bcd_digit_t load_digit,
   input  logic       step,
   input  logic       up,
   input  bcd_digit_t max,
   output bcd_digit_t digit,
   output logic       at_max,
   output logic       at_zero
);

   assign at_max  = (digit == max);
   assign at_zero = (digit == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         digit <= '0;
      end else if (load) begin
         digit <= bcd_clamp(load_digit, max);
      end else if (step) begin
         if (up) begin
            digit <= at_max ? '0 : digit + 1'b1;
         end else begin
            digit <= at_zero ? max : digit - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_counter_chain.sv
// ============================================================================
// Module : bcd_counter_chain
// Brief  : DIGITS-wide cascaded BCD up/down counter with preset and
//          terminal-count flags. Define BCD_CHAIN_SATURATE_EN to saturate
//          at all-max / all-zero instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_counter_chain
   import bcd_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int DIGIT_MAX = 9
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      up,
   input  logic                      load,
   input  logic [BCD_W*DIGITS-1:0]   load_value,
   output logic [BCD_W*DIGITS-1:0]   count,
   output logic                      rollover,
   output logic                      borrow,
   output logic                      zero
);

   localparam bcd_digit_t MAX_D = bcd_digit_t'(DIGIT_MAX);

   logic [DIGITS-1:0] at_max;
   logic [DIGITS-1:0] at_zero;
   logic [DIGITS-1:0] step;
   logic [DIGITS:0]   lo_max;
   logic [DIGITS:0]   lo_zero;
   logic              all_max;
   logic              all_zero;
   logic              hold;

   // lo_max[i] / lo_zero[i]: every digit below i is at its terminal value.
   always_comb begin
      lo_max     = '0;
      lo_zero    = '0;
      lo_max[0]  = 1'b1;
      lo_zero[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         lo_max[i+1]  = lo_max[i]  & at_max[i];
         lo_zero[i+1] = lo_zero[i] & at_zero[i];
      end
   end

   assign all_max  = lo_max[DIGITS];
   assign all_zero = lo_zero[DIGITS];

`ifdef BCD_CHAIN_SATURATE_EN
   assign hold = up ? all_max : all_zero;
`else
   assign hold = 1'b0;
`endif

   assign rollover = enable &  up & all_max  & ~load;
   assign borrow   = enable & ~up & all_zero & ~load;
   assign zero     = all_zero;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         assign step[i] = enable & ~load & ~hold & (up ? lo_max[i] : lo_zero[i]);

         bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[BCD_W*i +: BCD_W]),
            .step       (step[i]),
            .up         (up),
            .max        (MAX_D),
            .digit      (count[BCD_W*i +: BCD_W]),
            .at_max     (at_max[i]),
            .at_zero    (at_zero[i])
         );
      end
   endgenerate

`ifdef FORMAL
   logic seen_reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_reset <= 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_formal_digit
         always_comb begin
            if (seen_reset) begin
               assert (count[BCD_W*i +: BCD_W] <= MAX_D);
            end
         end
      end
   endgenerate

`ifndef BCD_CHAIN_SATURATE_EN
   assert property (@(posedge clk) disable iff (reset) rollover |=> (count == '0));
`endif
   cover property (@(posedge clk) disable iff (reset) rollover ##1 (count == '0));
   cover property (@(posedge clk) disable iff (reset) borrow ##1 all_max);
`endif

endmodule

`default_nettype wire
